// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync-FIFO write port among NUM_REQ requesters, bounded bursts.
// Grant registered one cycle after request; writes gated combinationally by full_i (stall holds ownership).
module fifo_wr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
    input  logic                     full_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       ack_o,
    output logic                     wr_en_o,
    output logic [WIDTH-1:0]         wdata_o,
    output logic                     busy_o,
    output logic [7:0]               stall_cnt_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [IW-1:0] LAST_RST  = IW'(NUM_REQ - 1);
    localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      r_last;
    logic [BW-1:0]      r_burst;
    logic [7:0]         r_stall;
    logic [NUM_REQ-1:0] r_gnt;

    logic [IW-1:0]      w_pick;
    logic [IW-1:0]      w_cand;
    logic               w_found;
    int                 w_idx;
    logic               w_owner_req;
    logic               w_wr;
    logic               w_stall;
    logic               w_end;

    // Walk from farthest to nearest so the candidate closest to last+1 wins.
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        w_idx   = 0;
        w_cand  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx  = (int'(r_last) + i) % NUM_REQ;
            w_cand = IW'(w_idx);
            if (req_i[w_cand]) begin
                w_pick  = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign w_owner_req = req_i[r_owner];
    assign w_wr        = (r_state == S_OWN) & w_owner_req & ~full_i & ~rst_i;
    assign w_stall     = (r_state == S_OWN) & w_owner_req & full_i;
    assign w_end       = (r_state == S_OWN) & (~w_owner_req | (w_wr & (r_burst == BURST_END)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_OWN;
            S_OWN:   if (w_end)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ack_o   = '0;
        wdata_o = '0;
        if (r_state == S_OWN) wdata_o = wdata_i[int'(r_owner)*WIDTH +: WIDTH];
        if (w_wr)             ack_o[r_owner] = 1'b1;
    end

    assign wr_en_o     = w_wr;
    assign busy_o      = (r_state == S_OWN);
    assign gnt_o       = r_gnt;
    assign stall_cnt_o = r_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_last  <= LAST_RST;
            r_burst <= '0;
            r_stall <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_found) begin
                r_owner <= w_pick;
                r_burst <= '0;
                r_gnt   <= NUM_REQ'(1) << w_pick;
            end
            if (w_end) begin
                r_last <= r_owner;
                r_gnt  <= '0;
            end else if (w_wr) begin
                r_burst <= r_burst + 1'b1;
            end
            // A stall never ends a burst; only the counter moves.
            if (w_stall && r_stall != 8'hFF) r_stall <= r_stall + 8'd1;
        end
    end

endmodule
